// File: rtl/mem_pkg.sv
// mem_pkg: shared load/store size encodings, memory FSM states and size helper
package mem_pkg;
  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_D  = 3'b011,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101,
    MEM_WU = 3'b110
  } funct3_e;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane mask, store shift, load extract/extend and misalignment for one 64-bit word
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] write_data,
  input  logic [63:0] raw,
  output logic [7:0]  mask,
  output logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic        misaligned
);
  logic [3:0]  size;
  logic [8:0]  ones;
  logic [63:0] sh;
  logic        sx;
  // decode size, align store data into lanes and pull load data down to bit 0
  always_comb begin
    size       = size_bytes(funct3);
    ones       = (9'd1 << size) - 9'd1;
    mask       = ones[7:0] << offset;
    misaligned = |(offset & (size[2:0] - 3'd1));
    store_data = write_data << {offset, 3'b000};
    sh         = raw >> {offset, 3'b000};
    sx         = ~funct3[2];
    load_data  = funct3[1:0] == 2'd0 ? {{56{sx & sh[7]}}, sh[7:0]} :
                 funct3[1:0] == 2'd1 ? {{48{sx & sh[15]}}, sh[15:0]} :
                 funct3[1:0] == 2'd2 ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
  end
endmodule

// File: rtl/sized_data_memory.sv
// sized_data_memory: byte-addressable RV64 data memory with sized accesses, fault flagging and a post-reset zeroing sweep
module sized_data_memory
  import mem_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 128,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  output logic            rsp_valid,
  output logic [XLEN-1:0] read_data,
  output logic            fault,
  output logic            init_busy
);
  state_e            state, state_n;
  logic [IDX_W-1:0]  cnt;
  logic [XLEN-1:0]   mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [XLEN-1:0]   raw, bmask, merged, store_data, load_data;
  logic [7:0]        mask;
  logic              misaligned, accept, fault_c, we_run;
  logic              unused_addr;

  assign idx         = address[IDX_W+2:3];
  assign unused_addr = ^address[XLEN-1:IDX_W+3];
  assign raw         = mem[idx];
  assign req_ready   = state == ST_RUN;
  assign init_busy   = state == ST_INIT;
  assign accept      = req_valid & req_ready;
  assign fault_c     = misaligned | (req_funct3 == 3'b111) | (req_write & req_funct3[2]);
  assign we_run      = accept & req_write & ~fault_c;
  assign merged      = (raw & ~bmask) | (store_data & bmask);

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign bmask[8*i+:8] = {8{mask[i]}};
  end

  mem_lane_align u_align (
    .funct3     (req_funct3),
    .offset     (address[2:0]),
    .write_data (write_data),
    .raw        (raw),
    .mask       (mask),
    .store_data (store_data),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // state and sweep counter; reset restarts the sweep from word 0
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == ST_INIT ? cnt + IDX_W'(1) : cnt;
    end

  // leave INIT once the last word has been zeroed
  always_comb begin
    state_n = state;
    if (state == ST_INIT && cnt == IDX_W'(DEPTH - 1)) state_n = ST_RUN;
  end

  // array write port: sweep zeroes during INIT, merged byte-lane stores in RUN
  always_ff @(posedge clk)
    if (state == ST_INIT) mem[cnt] <= '0;
    else if (we_run) mem[idx] <= merged;

  // one-cycle response; data only for clean loads
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rsp_valid <= 1'b0;
      fault     <= 1'b0;
      read_data <= '0;
    end else begin
      rsp_valid <= accept;
      fault     <= accept & fault_c;
      read_data <= (accept & ~req_write & ~fault_c) ? load_data : '0;
    end
endmodule

// File: tb/tb_sized_data_memory.sv
// tb_sized_data_memory: table-driven directed checks of sized loads/stores, faults, sweep timing and reset aborts
module tb_sized_data_memory;
  logic        clk = 0;
  logic        rstn = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [2:0]  req_funct3 = 3'b011;
  logic [63:0] address = '0;
  logic [63:0] write_data = '0;
  logic        rsp_valid;
  logic [63:0] read_data;
  logic        fault;
  logic        init_busy;
  int          total = 0;
  int          passed = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp;
    logic        efault;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sized_data_memory dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .address    (address),
    .write_data (write_data),
    .rsp_valid  (rsp_valid),
    .read_data  (read_data),
    .fault      (fault),
    .init_busy  (init_busy)
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", n, got, exp);
    else passed++;
  endtask

  // counts edges from now until req_ready is seen high
  task automatic wait_init(input string n);
    int k = 0;
    while (k < 300) begin
      @(posedge clk); #1;
      k++;
      if (req_ready) break;
    end
    chk(n, 64'(k), 64'd128);
  endtask

  // one request, response checked #1 after the accepting edge
  task automatic access(input string n, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] exp, input logic ef);
    @(negedge clk);
    req_valid = 1; req_write = wr; req_funct3 = f3; address = a; write_data = wd;
    @(posedge clk); #1;
    chk({n, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({n, ".fault"}, 64'(fault), 64'(ef));
    chk({n, ".data"}, read_data, exp);
    @(negedge clk);
    req_valid = 0;
  endtask

  initial begin
    vecs.push_back('{"sd08",     1, 3'b011, 64'h08, 64'h1122334455667788, 64'h0, 0});
    vecs.push_back('{"sb0b",     1, 3'b000, 64'h0B, 64'h00000000000000AA, 64'h0, 0});
    vecs.push_back('{"ld08",     0, 3'b011, 64'h08, 64'h0, 64'h11223344AA667788, 0});
    vecs.push_back('{"sd10",     1, 3'b011, 64'h10, 64'h8000000080FF7F80, 64'h0, 0});
    vecs.push_back('{"lb10",     0, 3'b000, 64'h10, 64'h0, 64'hFFFFFFFFFFFFFF80, 0});
    vecs.push_back('{"lbu10",    0, 3'b100, 64'h10, 64'h0, 64'h0000000000000080, 0});
    vecs.push_back('{"lh12",     0, 3'b001, 64'h12, 64'h0, 64'hFFFFFFFFFFFF80FF, 0});
    vecs.push_back('{"lw14",     0, 3'b010, 64'h14, 64'h0, 64'hFFFFFFFF80000000, 0});
    vecs.push_back('{"lwu14",    0, 3'b110, 64'h14, 64'h0, 64'h0000000080000000, 0});
    vecs.push_back('{"lh10",     0, 3'b001, 64'h10, 64'h0, 64'h0000000000007F80, 0});
    vecs.push_back('{"lhu12",    0, 3'b101, 64'h12, 64'h0, 64'h00000000000080FF, 0});
    vecs.push_back('{"lb11",     0, 3'b000, 64'h11, 64'h0, 64'h000000000000007F, 0});
    vecs.push_back('{"lw0a",     0, 3'b010, 64'h0A, 64'h0, 64'h0, 1});
    vecs.push_back('{"sh11",     1, 3'b001, 64'h11, 64'hBEEF, 64'h0, 1});
    vecs.push_back('{"ld_f7",    0, 3'b111, 64'h10, 64'h0, 64'h0, 1});
    vecs.push_back('{"st_f4",    1, 3'b100, 64'h10, 64'hFF, 64'h0, 1});
    vecs.push_back('{"st_f7",    1, 3'b111, 64'h08, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1});
    vecs.push_back('{"ld08_keep",0, 3'b011, 64'h08, 64'h0, 64'h11223344AA667788, 0});
    vecs.push_back('{"ld10_keep",0, 3'b011, 64'h10, 64'h0, 64'h8000000080FF7F80, 0});
    vecs.push_back('{"sd400",    1, 3'b011, 64'h400, 64'h5, 64'h0, 0});
    vecs.push_back('{"ld00",     0, 3'b011, 64'h00, 64'h0, 64'h5, 0});
    vecs.push_back('{"sh16",     1, 3'b001, 64'h16, 64'h1234, 64'h0, 0});
    vecs.push_back('{"ld10_sh",  0, 3'b011, 64'h10, 64'h0, 64'h1234000080FF7F80, 0});
    vecs.push_back('{"ld18",     0, 3'b011, 64'h18, 64'h0, 64'h0, 0});
    vecs.push_back('{"ld_hi",    0, 3'b011, 64'hFFFF000000000008, 64'h0, 64'h11223344AA667788, 0});

    // reset state, then sweep length with req_valid held high
    req_valid = 1; req_write = 0; req_funct3 = 3'b011; address = 64'h40;
    #12;
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.fault", 64'(fault), 64'd0);
    chk("rst.data", read_data, 64'd0);
    chk("rst.busy", 64'(init_busy), 64'd1);
    @(negedge clk); rstn = 1;
    wait_init("init_len");
    chk("run.busy", 64'(init_busy), 64'd0);
    @(posedge clk); #1;
    chk("ld40.valid", 64'(rsp_valid), 64'd1);
    chk("ld40.fault", 64'(fault), 64'd0);
    chk("ld40.data", read_data, 64'd0);
    @(negedge clk); req_valid = 0;
    @(posedge clk); #1;
    chk("idle.valid", 64'(rsp_valid), 64'd0);

    foreach (vecs[i]) access(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].efault);

    // back-to-back store then load to the same word
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'b011; address = 64'h20; write_data = 64'hCAFEF00D12345678;
    @(posedge clk); #1;
    chk("b2b.sd.valid", 64'(rsp_valid), 64'd1);
    chk("b2b.sd.data", read_data, 64'd0);
    @(negedge clk);
    req_write = 0; write_data = '0;
    @(posedge clk); #1;
    chk("b2b.ld.valid", 64'(rsp_valid), 64'd1);
    chk("b2b.ld.data", read_data, 64'hCAFEF00D12345678);
    @(negedge clk); req_valid = 0;
    @(posedge clk); #1;
    chk("b2b.idle", 64'(rsp_valid), 64'd0);

    // reset mid-sweep restarts the full sweep and re-zeroes the array
    @(negedge clk); rstn = 0;
    @(negedge clk); rstn = 1;
    repeat (60) @(posedge clk);
    #1;
    chk("mid.busy", 64'(init_busy), 64'd1);
    @(negedge clk); rstn = 0;
    #1;
    chk("mid.rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk); rstn = 1;
    wait_init("init_len2");
    access("ld08_zero", 0, 3'b011, 64'h08, 64'h0, 64'h0, 0);
    access("ld20_zero", 0, 3'b011, 64'h20, 64'h0, 64'h0, 0);

    // reset during the response cycle of a load kills the response
    @(negedge clk);
    req_valid = 1; req_write = 0; req_funct3 = 3'b011; address = 64'h00;
    @(posedge clk); #1;
    chk("abort.pre", 64'(rsp_valid), 64'd1);
    rstn = 0;
    #1;
    chk("abort.valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("abort.valid2", 64'(rsp_valid), 64'd0);
    chk("abort.ready", 64'(req_ready), 64'd0);
    req_valid = 0;
    @(negedge clk); rstn = 1;
    wait_init("init_len3");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sized_data_memory.md
# sized_data_memory

Parametrised, byte-addressable data memory for the RV64 core's MEM stage, succeeding the fixed 128×64 doubleword store. Supports every RV64I load/store size (byte, half, word, double) with sign/zero extension and byte-lane merging on stores. Flags misaligned and illegal accesses instead of silently writing. Zeroes its array with a post-reset sweep, so the array carries no reset fan-out.

## Interface
Parameters:
- XLEN, 64, data width in bits; must be 64 in this generation.
- DEPTH, 128, number of XLEN-bit words; power of two, ≥2.
- IDX_W, $clog2(DEPTH), word-index width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  reset; one clock; asynchronous assert, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal.
- address  in  64  byte address.
- write_data  in  64  store data, right-aligned (bits [size-1:0] used).
- rsp_valid  out  1  one-cycle response pulse.
- read_data  out  64  extended load result; 0 for stores and faults.
- fault  out  1  qualifies rsp_valid: misaligned or illegal access.
- init_busy  out  1  zeroing sweep in progress.

## Operation
- States: INIT, RUN. rstn low forces INIT, sweep counter = 0, and all outputs to 0. The array itself is not reset.
- INIT: writes 0 to word[counter] each cycle and increments the counter.
  - After writing word DEPTH-1, moves to RUN. This takes exactly DEPTH cycles after rstn rises.
  - init_busy = 1 and req_ready = 0 throughout INIT.
- RUN: req_ready = 1 constantly. An accepted request (req_valid && req_ready) is decoded as follows.
  - Word index = address[IDX_W+2:3]. Byte offset = address[2:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH*8.
  - Size from funct3[1:0]: 1, 2, 4 or 8 bytes.
  - Fault if funct3 = 111, or offset is not a multiple of the size. Also fault if funct3 = 111 on a store, or funct3[2] = 1 on a store (there are no unsigned stores).
  - Faulting access: no array write; response has fault = 1, read_data = 0.
  - Store: byte-enable mask = size ones shifted left by offset. Data is write_data shifted left by 8*offset. Only enabled bytes change.
  - Load: selects bytes at the offset and shifts them to bit 0. Sign-extends when funct3[2] = 0, zero-extends when funct3[2] = 1.
- rsp_valid, fault and read_data are registered and hold for exactly one cycle per accepted request; they are 0 otherwise.
- A reset asserted mid-sweep or mid-request aborts it. No response is produced, and the sweep restarts from word 0.

## Timing
- Latency: request accepted at edge N → rsp_valid high during cycle N+1. Throughput is one request per cycle, with no response backpressure.
- Store at edge N, then a load to the same word accepted at edge N+1 → the load returns the new data (write-before-read ordering).
- The array uses a synchronous write. The load read path may be combinational from the array into the response register.
- Reset values: req_ready 0, rsp_valid 0, fault 0, read_data 0. init_busy is 1 while rstn is low and during INIT.

## Structure
- Package mem_pkg holds:
  - funct3 enum (MEM_B, MEM_H, MEM_W, MEM_D, MEM_BU, MEM_HU, MEM_WU) and the state enum (ST_INIT, ST_RUN).
  - Function size_bytes(funct3), shared with the decode stage.
- Sub-module mem_lane_align: purely combinational. Maps (funct3, offset, write_data, raw word) to (byte mask, shifted store data, extended load data, misaligned). It is reused by the future cache.
- Top level: FSM, sweep counter, array, response registers.

## Test plan
- Reset, then hold req_valid = 1 → req_ready stays 0 for exactly 128 cycles after rstn rises. Then an ld at 0x40 returns 0 with fault = 0.
- sd 0x1122334455667788 @0x08, then sb 0xAA @0x0B → ld @0x08 returns 0x11223344AA667788.
- Same word 0x8000000080FF7F80 @0x10:
  - lb @0x10 → 0xFFFFFFFFFFFFFF80; lbu @0x10 → 0x80.
  - lh @0x12 → 0xFFFFFFFFFFFF80FF.
  - lw @0x14 → 0xFFFFFFFF80000000; lwu @0x14 → 0x80000000.
- lw @0x0A, sh @0x11, funct3 = 111, and a store with funct3 = 100 → each gives rsp_valid and fault = 1, read_data = 0, and memory is unchanged.
- Wrap-around and throughput:
  - sd 0x5 @0x400 (DEPTH = 128) → ld @0x000 returns 0x5.
  - Back-to-back sd/ld on consecutive cycles → ld returns the new value one cycle after acceptance.
- Mid-operation reset:
  - rstn pulsed low on cycle 60 of INIT → the sweep restarts and the full 128-cycle INIT repeats.
  - rstn pulsed low the cycle after a load is accepted → no rsp_valid.
